// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl: command-driven controller for a chain of BCD decade counters.
// Optional alarm/target compare is built when DECADE_CTRL_ALARM_EN is defined.
module decade_chain_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                dir_o,
  output logic                step,
  output logic                sup,
  output logic                inf,
  output logic                err,
  output logic                alarm
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LOADCHK
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           dir_q, dir_d;
  logic           ret_q, ret_d;
  logic           run_q, run_d;
  logic           err_q, err_d;
  logic           step_q, step_d;
  logic           sup_q, sup_d;
  logic           inf_q, inf_d;
`ifdef DECADE_CTRL_ALARM_EN
  logic [W-1:0]   tgt_q, tgt_d;
  logic           alarm_q, alarm_d;
`endif

  logic [W-1:0]   nxt_cnt;
  logic [3:0]     dig;
  logic           cy;
  logic           tick;
  logic           accept;
  logic           op_start, op_stop, op_clear;
  logic           op_load, op_dir, op_alarm;

  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign cmd_ready = (state_q != S_LOADCHK);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state_q == S_RUN) && (pre_q == PMAX);

  assign op_start = (cmd_op == 3'b001);
  assign op_stop  = (cmd_op == 3'b010);
  assign op_clear = (cmd_op == 3'b011);
  assign op_load  = (cmd_op == 3'b100);
  assign op_dir   = (cmd_op == 3'b101);
  assign op_alarm = (cmd_op == 3'b110);

  // Next BCD value one step up or down; cy is the carry/borrow out of the top digit.
  always_comb begin
    nxt_cnt = cnt_q;
    cy      = 1'b1;
    dig     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (cy) begin
        if (!dir_q) begin
          if (dig == 4'd9) begin
            nxt_cnt[4*i +: 4] = 4'd0;
          end else begin
            nxt_cnt[4*i +: 4] = dig + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nxt_cnt[4*i +: 4] = 4'd9;
          end else begin
            nxt_cnt[4*i +: 4] = dig - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  // Command handling, prescaler and stepping; an accepted command swallows a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    ret_d   = ret_q;
    err_d   = err_q;
    step_d  = 1'b0;
    sup_d   = 1'b0;
    inf_d   = 1'b0;
`ifdef DECADE_CTRL_ALARM_EN
    tgt_d   = tgt_q;
    alarm_d = 1'b0;
`endif
    if (state_q == S_LOADCHK) begin
      state_d = ret_q ? S_RUN : S_IDLE;
      if (bcd_ok(hold_q)) begin
        cnt_d = hold_q;
        pre_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (accept) begin
      if (state_q == S_RUN)
        pre_d = tick ? '0 : pre_q + 1'b1;
      unique case (1'b1)
        op_start: begin
          state_d = S_RUN;
          pre_d   = '0;
        end
        op_stop: begin
          state_d = S_IDLE;
          pre_d   = '0;
        end
        op_clear: begin
          cnt_d = '0;
          err_d = 1'b0;
          pre_d = '0;
        end
        op_load: begin
          hold_d  = cmd_data;
          ret_d   = (state_q == S_RUN);
          state_d = S_LOADCHK;
        end
        op_dir: dir_d = cmd_data[0];
`ifdef DECADE_CTRL_ALARM_EN
        op_alarm: begin
          if (bcd_ok(cmd_data)) tgt_d = cmd_data;
          else                  err_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end else if (tick) begin
      cnt_d  = nxt_cnt;
      pre_d  = '0;
      step_d = 1'b1;
      sup_d  = cy & ~dir_q;
      inf_d  = cy & dir_q;
`ifdef DECADE_CTRL_ALARM_EN
      if (nxt_cnt == tgt_q) begin
        alarm_d = 1'b1;
        state_d = S_IDLE;
      end
`endif
    end else if (state_q == S_RUN) begin
      pre_d = pre_q + 1'b1;
    end
    run_d = (state_d == S_RUN) ||
            ((state_d == S_LOADCHK) && ret_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      ret_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= 1'b0;
      sup_q   <= 1'b0;
      inf_q   <= 1'b0;
`ifdef DECADE_CTRL_ALARM_EN
      tgt_q   <= '0;
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      ret_q   <= ret_d;
      run_q   <= run_d;
      err_q   <= err_d;
      step_q  <= step_d;
      sup_q   <= sup_d;
      inf_q   <= inf_d;
`ifdef DECADE_CTRL_ALARM_EN
      tgt_q   <= tgt_d;
      alarm_q <= alarm_d;
`endif
    end
  end

  assign count   = cnt_q;
  assign running = run_q;
  assign dir_o   = dir_q;
  assign step    = step_q;
  assign sup     = sup_q;
  assign inf     = inf_q;
  assign err     = err_q;
`ifdef DECADE_CTRL_ALARM_EN
  assign alarm   = alarm_q;
`else
  assign alarm   = 1'b0;
  logic unused_ok;
  assign unused_ok = op_alarm;
`endif

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// tb_decade_chain_ctrl: directed vectors for decade_chain_ctrl.
// DUT a: DIGITS=2 PRESCALE=2; DUT b: DIGITS=4 PRESCALE=1.
module tb_decade_chain_ctrl;

  localparam logic [2:0] OP_START = 3'b001;
  localparam logic [2:0] OP_STOP  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_DIR   = 3'b101;
  localparam logic [2:0] OP_ALARM = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_valid, a_ready;
  logic [2:0]  a_op;
  logic [7:0]  a_data, a_count;
  logic        a_run, a_dir, a_step, a_sup, a_inf, a_err, a_alarm;

  logic        b_valid, b_ready;
  logic [2:0]  b_op;
  logic [15:0] b_data, b_count;
  logic        b_run, b_dir, b_step, b_sup, b_inf, b_err, b_alarm;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.DIGITS(2), .PRESCALE(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_data(a_data),
    .count(a_count), .running(a_run), .dir_o(a_dir),
    .step(a_step), .sup(a_sup), .inf(a_inf),
    .err(a_err), .alarm(a_alarm)
  );

  decade_chain_ctrl #(.DIGITS(4), .PRESCALE(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_data(b_data),
    .count(b_count), .running(b_run), .dir_o(b_dir),
    .step(b_step), .sup(b_sup), .inf(b_inf),
    .err(b_err), .alarm(b_alarm)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_cmd(input logic [2:0] op, input logic [7:0] d);
    a_valid = 1'b1;
    a_op    = op;
    a_data  = d;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_op    = 3'b000;
  endtask

  task automatic b_cmd(input logic [2:0] op, input logic [15:0] d);
    b_valid = 1'b1;
    b_op    = op;
    b_data  = d;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_op    = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    a_valid = 1'b0; a_op = '0; a_data = '0;
    b_valid = 1'b0; b_op = '0; b_data = '0;

    #22;
    chk("rst_count", a_count, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_flags",
        {a_run, a_dir, a_step, a_sup, a_inf, a_err, a_alarm}, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);

    a_cmd(OP_ALARM, 8'h55);
    b_cmd(OP_ALARM, 16'h5555);

    // count up, step every 2 cycles
    a_cmd(OP_START, 8'h00);
    chk("t1_run", a_run, 1);
    chk("t1_c0", a_count, 8'h00);
    for (int v = 1; v <= 12; v++) begin
      cyc(2);
      e = 8'((v / 10) * 16 + (v % 10));
      chk("t1_cnt", a_count, e);
      chk("t1_step", a_step, 1);
    end
    cyc(1);
    chk("t1_step_lo", a_step, 0);
    // LOAD in a tick cycle: tick suppressed
    a_cmd(OP_LOAD, 8'h98);
    chk("t1_supp", a_count, 8'h12);
    chk("t1_supp_step", a_step, 0);
    chk("t1_rdy_lo", a_ready, 0);
    cyc(1);
    chk("t1_ld98", a_count, 8'h98);
    chk("t1_rdy_hi", a_ready, 1);
    cyc(2);
    chk("t1_99", a_count, 8'h99);
    chk("t1_99_sup", a_sup, 0);
    cyc(2);
    chk("t1_wrap", a_count, 8'h00);
    chk("t1_wrap_fl", {a_step, a_sup, a_inf}, 3'b110);
    cyc(1);
    chk("t1_sup_lo", a_sup, 0);

    // count down
    a_cmd(OP_STOP, 8'h00);
    a_cmd(OP_CLEAR, 8'h00);
    a_cmd(OP_DIR, 8'h01);
    chk("t2_dir", a_dir, 1);
    chk("t2_idle", {a_run, a_count}, 9'h000);
    a_cmd(OP_START, 8'h00);
    cyc(2);
    chk("t2_99", a_count, 8'h99);
    chk("t2_fl", {a_step, a_sup, a_inf}, 3'b101);
    cyc(2);
    chk("t2_98", a_count, 8'h98);
    chk("t2_inf_lo", a_inf, 0);
    a_cmd(OP_LOAD, 8'h10);
    cyc(1);
    chk("t2_10", a_count, 8'h10);
    cyc(2);
    chk("t2_09", a_count, 8'h09);
    chk("t2_09_fl", {a_step, a_inf}, 2'b10);

    // bad LOAD in RUN, then CLEAR in a tick cycle
    a_cmd(OP_STOP, 8'h00);
    a_cmd(OP_DIR, 8'h00);
    a_cmd(OP_LOAD, 8'h42);
    cyc(1);
    chk("t3_42", {a_run, a_count}, 9'h042);
    a_cmd(OP_START, 8'h00);
    a_cmd(OP_LOAD, 8'h1A);
    chk("t3_rdy_lo", {a_ready, a_run}, 2'b01);
    cyc(1);
    chk("t3_keep", a_count, 8'h42);
    chk("t3_err", {a_err, a_ready, a_run}, 3'b111);
    a_cmd(OP_CLEAR, 8'h00);
    chk("t3_clr", a_count, 8'h00);
    chk("t3_clr_fl", {a_err, a_step, a_run}, 3'b001);
    cyc(2);
    chk("t3_01", {a_step, a_count}, 9'h101);

    // STOP in a tick cycle
    a_cmd(OP_STOP, 8'h00);
    a_cmd(OP_LOAD, 8'h16);
    cyc(1);
    a_cmd(OP_START, 8'h00);
    cyc(2);
    chk("t4_17", {a_step, a_count}, 9'h117);
    cyc(1);
    a_cmd(OP_STOP, 8'h00);
    chk("t4_stop", {a_run, a_step, a_count}, 10'h017);
    cyc(2);
    chk("t4_hold", {a_step, a_count}, 9'h017);

    // asynchronous reset mid-run
    a_cmd(OP_DIR, 8'h01);
    a_cmd(OP_START, 8'h00);
    cyc(2);
    chk("t5_16", a_count, 8'h16);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_count", a_count, 0);
    chk("t5_ready", a_ready, 1);
    chk("t5_flags",
        {a_run, a_dir, a_step, a_sup, a_inf, a_err, a_alarm}, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);

    // PRESCALE=1, four digits
    b_cmd(OP_ALARM, 16'h5555);
    b_cmd(OP_LOAD, 16'h9999);
    cyc(1);
    chk("t6_ld", b_count, 16'h9999);
    b_cmd(OP_START, 16'h0000);
    chk("t6_start", {b_run, b_step, b_count}, 18'h29999);
    cyc(1);
    chk("t6_wrap", b_count, 16'h0000);
    chk("t6_fl", {b_step, b_sup, b_inf}, 3'b110);
    cyc(1);
    chk("t6_0001", b_count, 16'h0001);
    chk("t6_fl2", {b_step, b_sup}, 2'b10);
    b_cmd(OP_STOP, 16'h0000);

    // alarm target
    a_cmd(OP_ALARM, 8'h05);
    a_cmd(OP_LOAD, 8'h03);
    cyc(1);
    chk("t7_err", a_err, 0);
    a_cmd(OP_START, 8'h00);
    cyc(2);
    chk("t7_04", {a_alarm, a_count}, 9'h004);
    cyc(2);
    chk("t7_05", a_count, 8'h05);
`ifdef DECADE_CTRL_ALARM_EN
    chk("t7_alarm", {a_alarm, a_run}, 2'b10);
    cyc(1);
    chk("t7_alarm_lo", a_alarm, 0);
    cyc(2);
    chk("t7_hold", {a_step, a_count}, 9'h005);
`else
    chk("t7_noalarm", {a_alarm, a_run}, 2'b01);
    cyc(2);
    chk("t7_06", {a_alarm, a_count}, 9'h006);
`endif
    a_cmd(OP_STOP, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/decade_chain_ctrl.md
# decade_chain_ctrl

Command-driven controller for a chain of DIGITS cascaded decade (BCD 0–9) counters. It owns the digit state and sequences start, stop, clear, preset load and direction changes through a valid/ready command port. A prescaler sets the step rate, and digit-to-digit carry/borrow is generated internally. It sits between the host/control logic and the display/timing datapath, and produces wrap flags in the same sup/inf sense as a single decade counter.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1..8.
- PRESCALE, 10: clock cycles per count step; legal range ≥ 1 (1 = step every cycle).
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  3  opcodes:
  - 000 NOP
  - 001 START
  - 010 STOP
  - 011 CLEAR
  - 100 LOAD
  - 101 SET_DIR
  - 110 SET_ALARM (macro only)
  - 111 NOP
- cmd_data  in  4*DIGITS  BCD operand for LOAD/SET_ALARM; bit 0 is the direction for SET_DIR (0 = up, 1 = down).
- count  out  4*DIGITS  current BCD value; digit 0 is in bits [3:0].
- running  out  1  high while in RUN.
- dir_o  out  1  current direction.
- step  out  1  one-cycle pulse in the cycle a new count value first appears.
- sup  out  1  one-cycle pulse on up-wrap, all 9s → 0.
- inf  out  1  one-cycle pulse on down-wrap, 0 → all 9s.
- err  out  1  sticky invalid-BCD load flag.
- alarm  out  1  one-cycle pulse on target match; tied 0 without the macro.

## Operation
- **States**
  - IDLE: not counting; count held.
  - RUN: prescaler advancing; steps taken.
  - LOADCHK: one cycle; validates the held LOAD operand.
- **Command acceptance**
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready = 1 in IDLE and RUN, 0 in LOADCHK.
  - Commands are accepted in any non-LOADCHK state.
- **START**
  - → RUN; prescaler cleared.
  - START while already in RUN restarts the prescaler only.
- **STOP**
  - → IDLE; prescaler cleared; count held.
- **CLEAR**
  - count = 0, err = 0, prescaler cleared.
  - State unchanged (RUN stays RUN).
- **LOAD**
  - cmd_data is captured into a holding register; → LOADCHK.
  - In LOADCHK, if every digit ≤ 9: count = operand and prescaler cleared. Otherwise count is unchanged and err = 1.
  - Next state is the state that was current when LOAD was accepted.
- **SET_DIR**
  - dir_o = cmd_data[0]; count and prescaler unaffected.
- **Prescaler**
  - Counts 0..PRESCALE-1 in RUN only; a tick occurs when it is at PRESCALE-1, then it wraps to 0.
  - If PRESCALE = 1, a tick occurs every RUN cycle.
- **Step, up**
  - Digit i increments if all lower digits are 9; a digit at 9 that increments becomes 0.
  - All 9s → all 0s, with sup pulsed.
- **Step, down**
  - Digit i decrements if all lower digits are 0; a digit at 0 that decrements becomes 9.
  - All 0s → all 9s, with inf pulsed.
- **Simultaneous events**
  - A command accepted in a tick cycle suppresses that tick: no step, and the prescaler goes to 0.
  - No tick occurs in LOADCHK; the prescaler holds there.
- **Reset**
  - Asynchronous, mid-operation included. State = IDLE, count = 0, dir_o = 0, prescaler = 0, running = 0, cmd_ready = 1.
  - step, sup, inf, err and alarm = 0; the alarm target = 0.

## Timing
- All outputs are registered; there is no combinational path from cmd_* to any output except cmd_ready, which depends on state only.
- **START** accepted at edge k:
  - running = 1 after edge k.
  - First step edge is k+PRESCALE; step, sup and inf are valid in the cycle after that edge, together with the new count.
  - Subsequent steps are every PRESCALE cycles.
- **STOP** accepted at edge k: running = 0 after k; no step at k or later.
- **LOAD** accepted at edge k:
  - cmd_ready = 0 for the cycle after k.
  - count (or err) updates at edge k+1.
  - If in RUN, the next step is at k+1+PRESCALE.
- **CLEAR**, **SET_DIR**: take effect at the accepting edge.

## Configuration
- DECADE_CTRL_ALARM_EN defined:
  - SET_ALARM stores cmd_data as the target. Only digits ≤ 9 are stored; otherwise err = 1 and the target is unchanged.
  - When a step produces count == target, alarm pulses with that step and the state goes to IDLE (running = 0 from the same edge).
  - CLEAR/LOAD making count equal the target does not fire alarm.
- Undefined:
  - Opcode 110 behaves as NOP.
  - alarm is constant 0; no target register.

## Test plan
- PRESCALE=2, DIGITS=2, START from 00 up → steps every 2 cycles 00,01,…,09,10; count 99 then 00 with sup=1 for one cycle, inf=0.
- SET_DIR 1, START from 00 → first step 99 with inf=1; next 98; 10 → 09.
- LOAD 0x1A (digit 0 = 0xA) in RUN at count 42 → count stays 42, err=1, cmd_ready low one cycle, still running; CLEAR → count 00, err 0.
- STOP accepted in the same cycle as a tick at count 17 → count stays 17, step=0, running=0; rst_n low mid-RUN → all outputs at reset values immediately.
- Macro on, SET_ALARM 05, LOAD 03, START up → steps 04, 05 with alarm=1, running=0 after that edge; count holds 05.
- PRESCALE=1, DIGITS=4, LOAD 9999, START → next cycle count 0000, sup=1, step=1.
